// File: rtl/ahb_burst_sequencer_if.sv
// Command, write-data, read-data and AHB-Lite master-side signals of the burst sequencer.
// The master modport is the sequencer's view and the slave modport is the stimulus/bus side.
interface ahb_burst_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_write;
    logic [2:0]        cmd_burst;
    logic [2:0]        cmd_size;
    logic [4:0]        cmd_len;
    logic [1:0]        cmd_sel;

    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;

    logic              hready;
    logic              hresp;
    logic [DATA_W-1:0] hrdata;

    logic              enable;
    logic [ADDR_W-1:0] in_haddr;
    logic [1:0]        in_htrans;
    logic              in_hwrite;
    logic [2:0]        in_hsize;
    logic [2:0]        in_hburst;
    logic [1:0]        in_hsel;
    logic [DATA_W-1:0] in_hwdata;

    logic              rdata_valid;
    logic [DATA_W-1:0] rdata;
    logic              done;
    logic              err;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_burst, cmd_size, cmd_len, cmd_sel,
        input  wdata_valid, wdata, hready, hresp, hrdata,
        output cmd_ready, wdata_ready, enable, in_haddr, in_htrans, in_hwrite, in_hsize,
        output in_hburst, in_hsel, in_hwdata, rdata_valid, rdata, done, err
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_burst, cmd_size, cmd_len, cmd_sel,
        output wdata_valid, wdata, hready, hresp, hrdata,
        input  cmd_ready, wdata_ready, enable, in_haddr, in_htrans, in_hwrite, in_hsize,
        input  in_hburst, in_hsel, in_hwdata, rdata_valid, rdata, done, err
    );
endinterface

// File: rtl/ahb_burst_sequencer.sv
// Expands one burst command into an AHB-Lite NONSEQ/SEQ/BUSY beat sequence with pipelined
// address and data phases, hready stalls and two-cycle ERROR abort.
module ahb_burst_sequencer #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  hresetn,
    ahb_burst_sequencer_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA_LAST, S_ERR} state_t;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_BUSY   = 2'b01;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] keep_q, keep_d;
    logic              write_q, write_d;
    logic [2:0]        size_q, size_d;
    logic [2:0]        burst_q, burst_d;
    logic [1:0]        sel_q, sel_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [4:0]        beats_q, beats_d;
    logic              first_q, first_d;
    logic              dphase_q, dphase_d;
    logic              stall_q, stall_d;
    logic [1:0]        hold_q, hold_d;

    logic [2:0]        size_eff;
    logic [2:0]        log_beats;
    logic [4:0]        cmd_beats;
    logic              wrap_cmd;
    logic [ADDR_W-1:0] wrap_span;
    logic [ADDR_W-1:0] addr_inc;
    logic [ADDR_W-1:0] addr_next;
    logic [1:0]        trans_pick;
    logic [1:0]        htrans;
    logic              addr_done;
    logic              rvalid;
    logic              done_w;
    logic              err_w;
    logic              cmd_ready_w;
    logic              load;

    // Command decode: beat count, effective size and the fixed-bit mask for wrapping bursts.
    always_comb begin
        size_eff  = (bus.cmd_size > 3'd2) ? 3'd2 : bus.cmd_size;
        wrap_cmd  = 1'b0;
        log_beats = 3'd0;
        cmd_beats = 5'd1;
        case (bus.cmd_burst)
            3'b000:  cmd_beats = 5'd1;
            3'b001:  cmd_beats = (bus.cmd_len == 5'd0) ? 5'd1 : bus.cmd_len;
            3'b010:  begin cmd_beats = 5'd4;  log_beats = 3'd2; wrap_cmd = 1'b1; end
            3'b011:  begin cmd_beats = 5'd4;  log_beats = 3'd2; end
            3'b100:  begin cmd_beats = 5'd8;  log_beats = 3'd3; wrap_cmd = 1'b1; end
            3'b101:  begin cmd_beats = 5'd8;  log_beats = 3'd3; end
            3'b110:  begin cmd_beats = 5'd16; log_beats = 3'd4; wrap_cmd = 1'b1; end
            default: begin cmd_beats = 5'd16; log_beats = 3'd4; end
        endcase
        wrap_span = (ADDR_W'(1) << (log_beats + size_eff)) - ADDR_W'(1);
    end

    // Bits set in keep_q stay fixed across the burst; the rest follow the incremented address.
    assign addr_inc = addr_q + (ADDR_W'(1) << size_q);
    generate
        for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_addr_next
            assign addr_next[gi] = keep_q[gi] ? addr_q[gi] : addr_inc[gi];
        end
    endgenerate

    // A write beat is offered only while its data word is waiting; once offered under a
    // stall, the transfer type is frozen until hready returns.
    always_comb begin
        if (write_q && !bus.wdata_valid) trans_pick = first_q ? HT_IDLE : HT_BUSY;
        else                             trans_pick = first_q ? HT_NONSEQ : HT_SEQ;
        htrans = HT_IDLE;
        if (state_q == S_ADDR) htrans = stall_q ? hold_q : trans_pick;
    end

    assign addr_done   = (state_q == S_ADDR) && bus.hready && htrans[1];
    assign rvalid      = dphase_q && bus.hready && !bus.hresp && !write_q;
    assign done_w      = bus.hready && ((state_q == S_DATA_LAST) || (state_q == S_ERR));
    assign err_w       = bus.hready && (state_q == S_ERR);
    assign cmd_ready_w = (state_q == S_IDLE) || done_w;
    assign load        = bus.cmd_valid && cmd_ready_w;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        keep_d   = keep_q;
        write_d  = write_q;
        size_d   = size_q;
        burst_d  = burst_q;
        sel_d    = sel_q;
        hwdata_d = hwdata_q;
        beats_d  = beats_q;
        first_d  = first_q;
        dphase_d = dphase_q;
        stall_d  = 1'b0;
        hold_d   = htrans;
        rdata_d  = rvalid ? bus.hrdata : rdata_q;
        case (state_q)
            S_ADDR: begin
                if (dphase_q && bus.hresp && !bus.hready) begin
                    state_d = S_ERR;
                end else if (!bus.hready) begin
                    stall_d = 1'b1;
                end else begin
                    dphase_d = addr_done;
                    if (addr_done) begin
                        if (write_q) hwdata_d = bus.wdata;
                        beats_d = beats_q - 5'd1;
                        first_d = 1'b0;
                        if (beats_q == 5'd1) state_d = S_DATA_LAST;
                        else                 addr_d  = addr_next;
                    end
                end
            end
            S_DATA_LAST: begin
                if (bus.hresp && !bus.hready) begin
                    state_d = S_ERR;
                end else if (bus.hready) begin
                    state_d  = S_IDLE;
                    dphase_d = 1'b0;
                end
            end
            S_ERR: begin
                if (bus.hready) begin
                    state_d  = S_IDLE;
                    dphase_d = 1'b0;
                end
            end
            default: ;
        endcase
        if (load) begin
            state_d  = S_ADDR;
            addr_d   = bus.cmd_addr;
            keep_d   = wrap_cmd ? ~wrap_span : '0;
            write_d  = bus.cmd_write;
            size_d   = size_eff;
            burst_d  = bus.cmd_burst;
            sel_d    = bus.cmd_sel;
            beats_d  = cmd_beats;
            first_d  = 1'b1;
            dphase_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            keep_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 3'd0;
            burst_q  <= 3'd0;
            sel_q    <= 2'd0;
            hwdata_q <= '0;
            rdata_q  <= '0;
            beats_q  <= 5'd0;
            first_q  <= 1'b0;
            dphase_q <= 1'b0;
            stall_q  <= 1'b0;
            hold_q   <= HT_IDLE;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            keep_q   <= keep_d;
            write_q  <= write_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            sel_q    <= sel_d;
            hwdata_q <= hwdata_d;
            rdata_q  <= rdata_d;
            beats_q  <= beats_d;
            first_q  <= first_d;
            dphase_q <= dphase_d;
            stall_q  <= stall_d;
            hold_q   <= hold_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready_w;
    assign bus.wdata_ready = addr_done && write_q;
    assign bus.enable      = (state_q != S_IDLE);
    assign bus.in_haddr    = addr_q;
    assign bus.in_htrans   = htrans;
    assign bus.in_hwrite   = write_q;
    assign bus.in_hsize    = size_q;
    assign bus.in_hburst   = burst_q;
    assign bus.in_hsel     = sel_q;
    assign bus.in_hwdata   = hwdata_q;
    // Read data is presented in the same cycle as its strobe and held afterwards.
    assign bus.rdata_valid = rvalid;
    assign bus.rdata       = rvalid ? bus.hrdata : rdata_q;
    assign bus.done        = done_w;
    assign bus.err         = err_w;
endmodule

// File: tb/tb_ahb_burst_sequencer.sv
// Directed bench for ahb_burst_sequencer: a table of error-free bursts plus hand-written
// stall, BUSY, ERROR and mid-burst reset sequences.
module tb_ahb_burst_sequencer;
    logic clk = 1'b0;
    logic hresetn = 1'b0;
    always #5 clk = ~clk;

    ahb_burst_sequencer_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    ahb_burst_sequencer #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk),
        .hresetn(hresetn),
        .bus(bus)
    );

    localparam logic [1:0] ID = 2'b00;
    localparam logic [1:0] BZ = 2'b01;
    localparam logic [1:0] NS = 2'b10;
    localparam logic [1:0] SQ = 2'b11;

    typedef struct packed {
        logic            write;
        logic [2:0]      burst;
        logic [2:0]      size;
        logic [4:0]      len;
        logic [1:0]      sel;
        logic [31:0]     addr;
        logic [4:0]      nbeats;
        logic [2:0]      esize;
        logic [7:0][31:0] exp;
    } vec_t;

    vec_t        vecs [8];
    int          errors = 0;
    int          checks = 0;
    int          cyc_cnt = 0;
    int          wd_idx = 0;
    logic [31:0] wbase = 32'h0;
    logic        pop_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; model the write-data source and hrdata.
    task automatic adv();
        @(posedge clk);
        #1;
        if (pop_seen) begin
            wd_idx++;
            bus.wdata = wbase + 32'(wd_idx);
        end
        pop_seen = 1'b0;
        cyc_cnt++;
        bus.hrdata = 32'hD000_0000 + 32'(cyc_cnt);
    endtask

    task automatic settle();
        @(negedge clk);
        pop_seen = bus.wdata_ready & bus.wdata_valid;
    endtask

    task automatic issue(input logic w, input logic [2:0] b, input logic [2:0] s,
                         input logic [4:0] l, input logic [1:0] sel, input logic [31:0] a);
        adv();
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_burst = b;
        bus.cmd_size  = s;
        bus.cmd_len   = l;
        bus.cmd_sel   = sel;
        bus.cmd_addr  = a;
        settle();
        chk("cmd_ready_before_accept", 32'(bus.cmd_ready), 32'd1);
        adv();
        bus.cmd_valid = 1'b0;
    endtask

    function automatic vec_t mk(input logic w, input logic [2:0] b, input logic [2:0] s,
                                input logic [4:0] l, input logic [1:0] sel, input logic [31:0] a,
                                input logic [4:0] n, input logic [2:0] es,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic [31:0] a2, input logic [31:0] a3,
                                input logic [31:0] a4, input logic [31:0] a5,
                                input logic [31:0] a6, input logic [31:0] a7);
        vec_t v;
        v.write = w; v.burst = b; v.size = s; v.len = l; v.sel = sel; v.addr = a;
        v.nbeats = n; v.esize = es;
        v.exp[0] = a0; v.exp[1] = a1; v.exp[2] = a2; v.exp[3] = a3;
        v.exp[4] = a4; v.exp[5] = a5; v.exp[6] = a6; v.exp[7] = a7;
        return v;
    endfunction

    task automatic data_chk(input logic w, input logic [31:0] exp_wd, input string tag);
        if (w) begin
            chk({tag, "_hwdata"}, bus.in_hwdata, exp_wd);
        end else begin
            chk({tag, "_rvalid"}, 32'(bus.rdata_valid), 32'd1);
            chk({tag, "_rdata"}, bus.rdata, bus.hrdata);
        end
    endtask

    task automatic run_vec(input int vi);
        vec_t v;
        string tag;
        v = vecs[vi];
        wbase = 32'(vi + 1) << 24;
        wd_idx = 0;
        bus.wdata = wbase;
        bus.wdata_valid = v.write;
        bus.hready = 1'b1;
        bus.hresp = 1'b0;
        issue(v.write, v.burst, v.size, v.len, v.sel, v.addr);
        for (int i = 0; i < int'(v.nbeats); i++) begin
            tag = $sformatf("v%0d_b%0d", vi, i);
            settle();
            chk({tag, "_htrans"}, 32'(bus.in_htrans), (i == 0) ? 32'(NS) : 32'(SQ));
            chk({tag, "_haddr"}, bus.in_haddr, v.exp[i]);
            chk({tag, "_done"}, 32'(bus.done), 32'd0);
            if (i == 0) begin
                chk({tag, "_hsize"}, 32'(bus.in_hsize), 32'(v.esize));
                chk({tag, "_hburst"}, 32'(bus.in_hburst), 32'(v.burst));
                chk({tag, "_hsel"}, 32'(bus.in_hsel), 32'(v.sel));
                chk({tag, "_hwrite"}, 32'(bus.in_hwrite), 32'(v.write));
                chk({tag, "_enable"}, 32'(bus.enable), 32'd1);
                if (!v.write) chk({tag, "_rvalid0"}, 32'(bus.rdata_valid), 32'd0);
            end else begin
                data_chk(v.write, wbase + 32'(i - 1), tag);
            end
            adv();
        end
        tag = $sformatf("v%0d_end", vi);
        settle();
        chk({tag, "_htrans"}, 32'(bus.in_htrans), 32'(ID));
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        data_chk(v.write, wbase + 32'(v.nbeats) - 32'd1, tag);
        adv();
    endtask

    // INCR8 write, hready low during beat 3 data phase (cycles 4 and 5 after accept).
    task automatic seq_stall();
        int k;
        int done_k;
        wbase = 32'h6000_0000; wd_idx = 0; bus.wdata = wbase; bus.wdata_valid = 1'b1;
        issue(1'b1, 3'b101, 3'd2, 5'd0, 2'd1, 32'h300);
        k = 1; done_k = 0;
        while (done_k == 0 && k <= 30) begin
            bus.hready = (k == 4 || k == 5) ? 1'b0 : 1'b1;
            settle();
            if (k == 4 || k == 5) begin
                chk($sformatf("stall_k%0d_htrans", k), 32'(bus.in_htrans), 32'(SQ));
                chk($sformatf("stall_k%0d_haddr", k), bus.in_haddr, 32'h30C);
                chk($sformatf("stall_k%0d_hwdata", k), bus.in_hwdata, wbase + 32'd2);
                chk($sformatf("stall_k%0d_wready", k), 32'(bus.wdata_ready), 32'd0);
            end
            if (bus.done) done_k = k;
            adv();
            k++;
        end
        bus.hready = 1'b1;
        chk("stall_done_cycle", 32'(done_k), 32'd11);
    endtask

    // INCR4 write with the second data word late by one cycle.
    task automatic seq_busy();
        int k;
        int done_k;
        logic [1:0]  eht [6];
        logic [31:0] ead [6];
        eht[1] = NS; eht[2] = BZ; eht[3] = SQ; eht[4] = SQ; eht[5] = SQ;
        ead[1] = 32'h200; ead[2] = 32'h204; ead[3] = 32'h204; ead[4] = 32'h208; ead[5] = 32'h20C;
        wbase = 32'h5000_0000; wd_idx = 0; bus.wdata = wbase; bus.wdata_valid = 1'b1;
        issue(1'b1, 3'b011, 3'd2, 5'd0, 2'd0, 32'h200);
        k = 1; done_k = 0;
        while (done_k == 0 && k <= 30) begin
            bus.wdata_valid = (k == 2) ? 1'b0 : 1'b1;
            settle();
            if (k <= 5) begin
                chk($sformatf("busy_k%0d_htrans", k), 32'(bus.in_htrans), 32'(eht[k]));
                chk($sformatf("busy_k%0d_haddr", k), bus.in_haddr, ead[k]);
            end
            if (k == 2) chk("busy_k2_wready", 32'(bus.wdata_ready), 32'd0);
            if (k >= 3 && k <= 6)
                chk($sformatf("busy_k%0d_hwdata", k), bus.in_hwdata, wbase + 32'(k - 3));
            if (bus.done) done_k = k;
            adv();
            k++;
        end
        chk("busy_done_cycle", 32'(done_k), 32'd6);
    endtask

    // INCR16 read, two-cycle ERROR on the fifth beat's data phase.
    task automatic seq_error();
        int k;
        int done_k;
        int rv;
        logic err_seen;
        bus.wdata_valid = 1'b0;
        issue(1'b0, 3'b111, 3'd2, 5'd0, 2'd2, 32'h1000);
        k = 1; done_k = 0; rv = 0; err_seen = 1'b0;
        while (done_k == 0 && k <= 30) begin
            bus.hready = (k == 6) ? 1'b0 : 1'b1;
            bus.hresp  = (k == 6 || k == 7);
            settle();
            if (bus.rdata_valid) rv++;
            if (k == 5) chk("err_k5_haddr", bus.in_haddr, 32'h1010);
            if (k == 6) chk("err_k6_htrans", 32'(bus.in_htrans), 32'(SQ));
            if (k == 7) chk("err_k7_htrans", 32'(bus.in_htrans), 32'(ID));
            if (bus.done) begin
                done_k = k;
                err_seen = bus.err;
            end
            adv();
            k++;
        end
        bus.hready = 1'b1;
        bus.hresp = 1'b0;
        settle();
        chk("err_after_htrans", 32'(bus.in_htrans), 32'(ID));
        chk("err_after_enable", 32'(bus.enable), 32'd0);
        adv();
        chk("err_rvalid_count", 32'(rv), 32'd4);
        chk("err_done_cycle", 32'(done_k), 32'd7);
        chk("err_flag", 32'(err_seen), 32'd1);
    endtask

    // Reset asserted in the middle of an INCR8 write, then a SINGLE write.
    task automatic seq_reset();
        wbase = 32'h4000_0000; wd_idx = 0; bus.wdata = wbase; bus.wdata_valid = 1'b1;
        issue(1'b1, 3'b101, 3'd2, 5'd0, 2'd3, 32'h400);
        for (int k = 1; k <= 3; k++) begin
            settle();
            adv();
        end
        settle();
        hresetn = 1'b0;
        #1;
        chk("rst_htrans", 32'(bus.in_htrans), 32'd0);
        chk("rst_haddr", bus.in_haddr, 32'd0);
        chk("rst_hwdata", bus.in_hwdata, 32'd0);
        chk("rst_hsel", 32'(bus.in_hsel), 32'd0);
        chk("rst_hburst", 32'(bus.in_hburst), 32'd0);
        chk("rst_hwrite", 32'(bus.in_hwrite), 32'd0);
        chk("rst_enable", 32'(bus.enable), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_wready", 32'(bus.wdata_ready), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        adv();
        adv();
        hresetn = 1'b1;
        wbase = 32'h7777_0000; wd_idx = 0; bus.wdata = wbase; bus.wdata_valid = 1'b1;
        issue(1'b1, 3'b000, 3'd2, 5'd0, 2'd1, 32'h44);
        settle();
        chk("single_htrans", 32'(bus.in_htrans), 32'(NS));
        chk("single_haddr", bus.in_haddr, 32'h44);
        chk("single_done_early", 32'(bus.done), 32'd0);
        adv();
        settle();
        chk("single_done", 32'(bus.done), 32'd1);
        chk("single_err", 32'(bus.err), 32'd0);
        chk("single_hwdata", bus.in_hwdata, wbase);
        adv();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(1'b1, 3'b011, 3'd2, 5'd0, 2'd1, 32'h10, 5'd4, 3'd2,
                     32'h10, 32'h14, 32'h18, 32'h1C, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[1] = mk(1'b0, 3'b010, 3'd2, 5'd0, 2'd2, 32'h38, 5'd4, 3'd2,
                     32'h38, 32'h3C, 32'h30, 32'h34, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[2] = mk(1'b1, 3'b100, 3'd0, 5'd0, 2'd3, 32'h05, 5'd8, 3'd0,
                     32'h05, 32'h06, 32'h07, 32'h00, 32'h01, 32'h02, 32'h03, 32'h04);
        vecs[3] = mk(1'b1, 3'b001, 3'd1, 5'd3, 2'd0, 32'hFFFF_FFFC, 5'd3, 3'd1,
                     32'hFFFF_FFFC, 32'hFFFF_FFFE, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[4] = mk(1'b0, 3'b000, 3'd7, 5'd0, 2'd1, 32'h40, 5'd1, 3'd2,
                     32'h40, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[5] = mk(1'b0, 3'b001, 3'd2, 5'd0, 2'd2, 32'h80, 5'd1, 3'd2,
                     32'h80, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[6] = mk(1'b1, 3'b010, 3'd1, 5'd0, 2'd0, 32'h106, 5'd4, 3'd1,
                     32'h106, 32'h100, 32'h102, 32'h104, 32'h0, 32'h0, 32'h0, 32'h0);
        vecs[7] = mk(1'b0, 3'b101, 3'd0, 5'd0, 2'd3, 32'h03, 5'd8, 3'd0,
                     32'h03, 32'h04, 32'h05, 32'h06, 32'h07, 32'h08, 32'h09, 32'h0A);

        bus.cmd_valid = 1'b0; bus.cmd_addr = 32'h0; bus.cmd_write = 1'b0;
        bus.cmd_burst = 3'd0; bus.cmd_size = 3'd0; bus.cmd_len = 5'd0; bus.cmd_sel = 2'd0;
        bus.wdata_valid = 1'b0; bus.wdata = 32'h0;
        bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = 32'h0;

        settle();
        chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("reset_htrans", 32'(bus.in_htrans), 32'd0);
        chk("reset_enable", 32'(bus.enable), 32'd0);
        chk("reset_haddr", bus.in_haddr, 32'd0);
        chk("reset_hwdata", bus.in_hwdata, 32'd0);
        chk("reset_wready", 32'(bus.wdata_ready), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_rvalid", 32'(bus.rdata_valid), 32'd0);
        adv();
        hresetn = 1'b1;

        for (int vi = 0; vi < 8; vi++) run_vec(vi);
        seq_stall();
        seq_busy();
        seq_error();
        seq_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ahb_burst_sequencer.md
# ahb_burst_sequencer

Master-side command sequencer that drives the `in_*` stimulus ports of `top_ahb`. It accepts one burst command at a time and expands it into a legal AHB-Lite beat sequence: NONSEQ, then SEQ or BUSY, with incrementing or wrapping addresses. It pipelines address and data phases, honours `hready` stalls, and aborts on an ERROR response. It replaces hand-timed task stimulus and is the single owner of the `top_ahb` master inputs.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  system clock; all logic on rising edge
- hresetn  in  1  reset, asynchronous assert, active-low
- cmd_valid  in  1  burst command valid
- cmd_ready  out  1  sequencer idle, accepts command
- cmd_addr  in  ADDR_W  start address
- cmd_write  in  1  1 = write burst, 0 = read burst
- cmd_burst  in  3  HBURST encoding (000 SINGLE … 111 INCR16)
- cmd_size  in  3  HSIZE (0 byte, 1 half, 2 word; values above 2 are treated as 2)
- cmd_len  in  5  beat count for INCR (001) only, range 1..16; 0 is treated as 1
- cmd_sel  in  2  slave select, held for the whole burst
- wdata_valid / wdata_ready  in/out  1  write-data handshake, one word per beat
- wdata  in  DATA_W  write data
- hready  in  1  transfer ready from the bus (tie 1 if unused)
- hresp  in  1  0 OKAY, 1 ERROR
- hrdata  in  DATA_W  read data (from `out_hrdata`)
- enable  out  1  drives `top_ahb.enable`
- in_haddr, in_htrans (2), in_hwrite, in_hsize (3), in_hburst (3), in_hsel (2), in_hwdata  out  drive the matching `top_ahb` ports
- rdata_valid  out  1  one-cycle strobe per completed read beat
- rdata  out  DATA_W  captured hrdata
- done  out  1  one-cycle strobe at end of burst
- err  out  1  qualifies `done`: burst ended on ERROR

## Operation
- Beat count: SINGLE = 1; WRAP4/INCR4 = 4; WRAP8/INCR8 = 8; WRAP16/INCR16 = 16; INCR = cmd_len.
- Address step = 1 << size. Incrementing bursts add the step.
- Wrapping bursts keep the address bits above log2(beats × step) fixed and wrap the low bits modulo (beats × step).
- All address arithmetic is ADDR_W bits, modulo 2^ADDR_W. No 1KB-boundary check.
- FSM states: IDLE, ADDR, DATA_LAST, ERR.
- IDLE: cmd_ready = 1, in_htrans = IDLE, enable = 0. The command is latched on cmd_valid & cmd_ready, then go to ADDR.
- ADDR: drives the current beat's address phase.
  - Beat 0 is NONSEQ; later beats are SEQ.
  - For a write beat, the beat is issued only when wdata_valid = 1. Otherwise the sequencer drives BUSY mid-burst, or holds NONSEQ back (drives IDLE) for beat 0.
  - The address phase completes when hready = 1 and the driven htrans is NONSEQ or SEQ.
  - On completion, wdata is popped (wdata_ready pulse in that cycle) into the hwdata register, and the beat counter decrements.
  - After the last beat's address phase completes, go to DATA_LAST.
- Data phase of each beat is the cycle(s) after its address phase completes, until hready = 1.
  - in_hwdata holds that beat's data for the whole data phase.
  - A read beat captures hrdata into rdata and pulses rdata_valid when its data phase ends with hready = 1 and hresp = OKAY.
- DATA_LAST: in_htrans = IDLE. When hready = 1: done = 1, err = 0, go to IDLE.
- ERROR handling: hresp = 1 with hready = 0 in any data phase is the first ERROR cycle.
  - The next address phase is forced to IDLE.
  - Go to ERR; the remaining beats are dropped.
  - In ERR, wait for hready = 1 (second ERROR cycle), then pulse done = 1 with err = 1 and go to IDLE.
  - A read beat that errors produces no rdata_valid.
- hwrite, hsize, hburst and hsel stay constant from NONSEQ through the last data phase.
- in_hburst carries the command encoding. enable = 1 in every state except IDLE.

## Timing
- Reset values: cmd_ready 1, wdata_ready 0, in_htrans 00, in_haddr 0, in_hwrite 0, in_hsize 0, in_hburst 0, in_hsel 0, in_hwdata 0, enable 0, rdata 0, rdata_valid 0, done 0, err 0. FSM resets to IDLE.
- Asserting hresetn mid-burst drops the burst immediately, with no done strobe.
- Command accepted at edge T: NONSEQ appears on the outputs after edge T (cycle T+1).
- With hready = 1 throughout and no starvation, an N-beat burst has address phases in cycles T+1..T+N and data phases in T+2..T+N+1. done is high in cycle T+N+1.
- A new command is accepted in the done cycle at the earliest. Back-to-back bursts have one idle cycle between them.
- hready = 0 freezes all in_* outputs and the beat counter.
- Each BUSY cycle delays the remaining beats by 1 cycle. A BUSY is never inserted after the last beat.
- rdata_valid for beat k coincides with the cycle in which the data phase of beat k completes.

## Test plan
- INCR4 write, addr 0x10, size 2, wdata 1,2,3,4, hready = 1:
  - haddr 0x10/0x14/0x18/0x1C with htrans NONSEQ/SEQ/SEQ/SEQ.
  - hwdata 1..4 each lagging its address by 1 cycle; done at T+5, err = 0.
- WRAP4 read, addr 0x38, size 2: haddr 0x38, 0x3C, 0x30, 0x34; 4 rdata_valid strobes return hrdata in order. WRAP8 byte burst at 0x05: haddr 05, 06, 07, 00, 01, 02, 03, 04.
- INCR8 write, hready = 0 for 2 cycles at beat 3: all in_* outputs held for those cycles, beat 3 data kept on hwdata, done delayed by 2 cycles.
- INCR4 write with wdata_valid low for 1 cycle before beat 2: exactly one BUSY cycle at the held address, then SEQ resumes; no wdata is lost.
- INCR16 read with hresp ERROR (2-cycle) on beat 5:
  - htrans = IDLE after the first ERROR cycle, no further beats.
  - rdata_valid count = 4; done with err = 1.
- hresetn low mid INCR8: all outputs return to their reset values asynchronously. A SINGLE write issued after release completes in 2 cycles.
